game_ctrl: RTL and testbench

//  Top-level game sequencer. Drives global_state and the board enable, and runs the round and countdown timers.

---
 rtl/game_ctrl_if.sv | 40 ++++
 rtl/game_ctrl.sv | 153 +++++++++++++++
 tb/tb_game_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/game_ctrl_if.sv
// Game controller bus: player/board stimulus in, sequencer state and display values out.
// master = stimulus side (bench or upstream glue), slave = game_ctrl.
interface game_ctrl_if;
  logic        start_btn;
  logic        score_trigger;
  logic [1:0]  global_state;
  logic        board_enable;
  logic [27:0] mole_time;
  logic [7:0]  score;
  logic [6:0]  time_left;
  logic [1:0]  countdown;
  logic        game_over;
  logic [7:0]  high_score;

  modport master (
    output start_btn,
    output score_trigger,
    input  global_state,
    input  board_enable,
    input  mole_time,
    input  score,
    input  time_left,
    input  countdown,
    input  game_over,
    input  high_score
  );

  modport slave (
    input  start_btn,
    input  score_trigger,
    output global_state,
    output board_enable,
    output mole_time,
    output score,
    output time_left,
    output countdown,
    output game_over,
    output high_score
  );
endinterface

// File: rtl/game_ctrl.sv
// Top-level game sequencer: IDLE -> READY (countdown) -> START (round) -> OVER.
// Runs the second tick, round/countdown timers, BCD score and mole_time difficulty level.
// Optional feature macro: HIGH_SCORE_EN keeps a BCD best-score register (cleared only by rst);
// without it high_score is tied to 8'h00.
module game_ctrl #(
  parameter int unsigned SEC_TICKS         = 10_000_000,
  parameter int unsigned COUNTDOWN_SECONDS = 3,
  parameter int unsigned GAME_SECONDS      = 60,
  parameter int unsigned LEVEL_HITS        = 10,
  parameter int unsigned MAX_LEVEL         = 3,
  parameter int unsigned BASE_MOLE_TIME    = 20_000_000,
  parameter int unsigned LEVEL_STEP        = 4_000_000
) (
  input  logic         clk,
  input  logic         rst,
  game_ctrl_if.slave   gi
);

  localparam int unsigned CntW = (SEC_TICKS > 1) ? $clog2(SEC_TICKS) : 1;
  localparam int unsigned HitW = (LEVEL_HITS > 1) ? $clog2(LEVEL_HITS) : 1;
  localparam int unsigned LvlW = (MAX_LEVEL > 0) ? $clog2(MAX_LEVEL + 1) : 1;

  localparam logic [CntW-1:0] TickLast  = CntW'(SEC_TICKS - 1);
  localparam logic [HitW-1:0] HitLast   = HitW'(LEVEL_HITS - 1);
  localparam logic [LvlW-1:0] LvlMax    = LvlW'(MAX_LEVEL);
  localparam logic [27:0]     BaseTime  = 28'(BASE_MOLE_TIME);
  localparam logic [27:0]     StepTime  = 28'(LEVEL_STEP);
  localparam logic [1:0]      CdLoad    = 2'(COUNTDOWN_SECONDS);
  localparam logic [6:0]      GameLoad  = 7'(GAME_SECONDS);

  // Encoding matches the global_state output values.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StReady = 2'd1,
    StStart = 2'd2,
    StOver  = 2'd3
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] tick_cnt_q;
  logic [HitW-1:0] hits_q;
  logic [LvlW-1:0] level_q;

  logic       tick;
  logic       running;
  logic       final_tick;
  logic [7:0] score_inc;
  logic [7:0] hit_score;

  // Tick decode, saturating BCD increment and the score as it will be after this cycle's hit.
  always_comb begin
    running    = (state_q == StReady) || (state_q == StStart);
    tick       = running && (tick_cnt_q == TickLast);
    final_tick = (state_q == StStart) && tick && (gi.time_left == 7'd1);
    score_inc  = gi.score;
    if (gi.score != 8'h99) begin
      if (gi.score[3:0] == 4'd9) begin
        score_inc = {gi.score[7:4] + 4'd1, 4'd0};
      end else begin
        score_inc = {gi.score[7:4], gi.score[3:0] + 4'd1};
      end
    end
    hit_score = gi.score_trigger ? score_inc : gi.score;
  end

  // Sequencer FSM with all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= StIdle;
      tick_cnt_q      <= '0;
      hits_q          <= '0;
      level_q         <= '0;
      gi.global_state <= 2'd0;
      gi.board_enable <= 1'b0;
      gi.mole_time    <= BaseTime;
      gi.score        <= 8'h00;
      gi.time_left    <= 7'd0;
      gi.countdown    <= 2'd0;
      gi.game_over    <= 1'b0;
    end else begin
      gi.game_over <= 1'b0;
      // Follows level one cycle later.
      gi.mole_time <= BaseTime - (28'(level_q) * StepTime);
      // The counter also returns to 0 on every transition, since transitions only leave
      // READY/START on a tick and enter READY from IDLE/OVER where it is held at 0.
      tick_cnt_q   <= (tick || !running) ? '0 : tick_cnt_q + 1'b1;

      unique case (state_q)
        StIdle, StOver: begin
          if (gi.start_btn) begin
            state_q         <= StReady;
            gi.global_state <= 2'd1;
            gi.score        <= 8'h00;
            hits_q          <= '0;
            level_q         <= '0;
            gi.countdown    <= CdLoad;
            tick_cnt_q      <= '0;
          end
        end
        StReady: begin
          if (tick) begin
            if (gi.countdown == 2'd1) begin
              state_q         <= StStart;
              gi.global_state <= 2'd2;
              gi.board_enable <= 1'b1;
              gi.time_left    <= GameLoad;
              gi.countdown    <= 2'd0;
            end else begin
              gi.countdown <= gi.countdown - 2'd1;
            end
          end
        end
        StStart: begin
          if (gi.score_trigger) begin
            gi.score <= score_inc;
            if (hits_q == HitLast) begin
              hits_q <= '0;
              if (level_q != LvlMax) level_q <= level_q + 1'b1;
            end else begin
              hits_q <= hits_q + 1'b1;
            end
          end
          if (final_tick) begin
            state_q         <= StOver;
            gi.global_state <= 2'd3;
            gi.board_enable <= 1'b0;
            gi.time_left    <= 7'd0;
            gi.game_over    <= 1'b1;
          end else if (tick) begin
            gi.time_left <= gi.time_left - 7'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef HIGH_SCORE_EN
  // Best score, captured on the same edge that raises game_over; includes a coincident hit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gi.high_score <= 8'h00;
    end else if (final_tick && (hit_score > gi.high_score)) begin
      gi.high_score <= hit_score;
    end
  end
`else
  assign gi.high_score = 8'h00;
  logic unused_hit_score;
  assign unused_hit_score = ^hit_score;
`endif

endmodule

// File: tb/tb_game_ctrl.sv
// Scoreboard bench for game_ctrl: expected values are queued when stimulus is driven and
// popped when the corresponding DUT output is sampled (#1 after the rising edge).
module tb_game_ctrl;

  localparam int unsigned SecTicks  = 4;
  localparam int unsigned CdSecs    = 3;
  localparam int unsigned GameSecs  = 30;
  localparam int unsigned LvlHits   = 10;
  localparam int unsigned MaxLvl    = 3;
  localparam int unsigned BaseTime  = 20_000_000;
  localparam int unsigned StepTime  = 4_000_000;
  localparam int          RoundCyc  = SecTicks * GameSecs;

  logic clk;
  logic rst;
  game_ctrl_if gif ();

  game_ctrl #(
    .SEC_TICKS        (SecTicks),
    .COUNTDOWN_SECONDS(CdSecs),
    .GAME_SECONDS     (GameSecs),
    .LEVEL_HITS       (LvlHits),
    .MAX_LEVEL        (MaxLvl),
    .BASE_MOLE_TIME   (BaseTime),
    .LEVEL_STEP       (StepTime)
  ) dut (
    .clk(clk),
    .rst(rst),
    .gi (gif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   m_score  = 0;
  int   m_high   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic sb_pop(input logic [31:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check(e.tag, obs, e.val);
    end
  endtask

  function automatic logic [31:0] to_bcd(input int v);
    return 32'(((v / 10) << 4) | (v % 10));
  endfunction

  function automatic int min_int(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full round: n_hits hits, optionally placing the last hit on the final tick.
  task automatic run_round(input int n_hits, input bit coincide);
    int p;
    int early;
    int lvl;
    gif.start_btn = 1'b1;
    step();
    gif.start_btn = 1'b0;
    for (int i = 0; i < 12; i++) begin
      sb_push("countdown", 32'(3 - i / 4));
      sb_pop(32'(gif.countdown));
      sb_push("state_ready", 32'd1);
      sb_pop(32'(gif.global_state));
      if (i == 5) gif.score_trigger = 1'b1;
      step();
      gif.score_trigger = 1'b0;
    end
    sb_push("state_start", 32'd2);      sb_pop(32'(gif.global_state));
    sb_push("board_en_start", 32'd1);   sb_pop(32'(gif.board_enable));
    sb_push("time_left_load", GameSecs); sb_pop(32'(gif.time_left));
    sb_push("countdown_zero", 32'd0);   sb_pop(32'(gif.countdown));
    sb_push("score_ready_ign", 32'd0);  sb_pop(32'(gif.score));

    m_score = 0;
    p = 0;
    early = coincide ? n_hits - 1 : n_hits;
    for (int h = 0; h < early; h++) begin
      gif.score_trigger = 1'b1;
      m_score = min_int(m_score + 1, 99);
      sb_push("score_hit", to_bcd(m_score));
      step();
      p++;
      gif.score_trigger = 1'b0;
      sb_pop(32'(gif.score));
      if (h == 11) begin
        sb_push("mole_time_lvl1", BaseTime - StepTime);
        sb_pop(32'(gif.mole_time));
      end
    end
    step();
    step();
    p += 2;
    lvl = min_int(early / LvlHits, MaxLvl);
    sb_push("mole_time", 32'(BaseTime - lvl * StepTime));
    sb_pop(32'(gif.mole_time));

    while (p < RoundCyc - 1) begin
      sb_push("time_left", 32'(GameSecs - p / SecTicks));
      sb_pop(32'(gif.time_left));
      step();
      p++;
    end
    sb_push("tl_last", 32'd1);        sb_pop(32'(gif.time_left));
    sb_push("state_last", 32'd2);     sb_pop(32'(gif.global_state));
    sb_push("go_before", 32'd0);      sb_pop(32'(gif.game_over));

    if (coincide) begin
      gif.score_trigger = 1'b1;
      m_score = min_int(m_score + 1, 99);
    end
`ifdef HIGH_SCORE_EN
    if (m_score > m_high) m_high = m_score;
`endif
    sb_push("score_final", to_bcd(m_score));
    sb_push("state_over", 32'd3);
    sb_push("game_over_pulse", 32'd1);
    sb_push("board_en_over", 32'd0);
    sb_push("tl_over", 32'd0);
    sb_push("high_score", to_bcd(m_high));
    step();
    gif.score_trigger = 1'b0;
    sb_pop(32'(gif.score));
    sb_pop(32'(gif.global_state));
    sb_pop(32'(gif.game_over));
    sb_pop(32'(gif.board_enable));
    sb_pop(32'(gif.time_left));
    sb_pop(32'(gif.high_score));
    step();
    sb_push("game_over_1cyc", 32'd0); sb_pop(32'(gif.game_over));
    sb_push("state_hold", 32'd3);     sb_pop(32'(gif.global_state));
    gif.score_trigger = 1'b1;
    step();
    gif.score_trigger = 1'b0;
    sb_push("score_over_ign", to_bcd(m_score));
    sb_pop(32'(gif.score));
  endtask

  initial begin
    rst = 1'b1;
    gif.start_btn = 1'b0;
    gif.score_trigger = 1'b0;
    step();
    step();
    sb_push("rst_state", 32'd0);        sb_pop(32'(gif.global_state));
    sb_push("rst_board_en", 32'd0);     sb_pop(32'(gif.board_enable));
    sb_push("rst_mole_time", BaseTime); sb_pop(32'(gif.mole_time));
    sb_push("rst_score", 32'd0);        sb_pop(32'(gif.score));
    sb_push("rst_time_left", 32'd0);    sb_pop(32'(gif.time_left));
    sb_push("rst_countdown", 32'd0);    sb_pop(32'(gif.countdown));
    sb_push("rst_game_over", 32'd0);    sb_pop(32'(gif.game_over));
    sb_push("rst_high", 32'd0);         sb_pop(32'(gif.high_score));
    rst = 1'b0;
    step();

    // Hits in IDLE are ignored.
    gif.score_trigger = 1'b1;
    step();
    gif.score_trigger = 1'b0;
    sb_push("score_idle_ign", 32'd0);   sb_pop(32'(gif.score));
    sb_push("state_idle", 32'd0);       sb_pop(32'(gif.global_state));

    // Long round: BCD carries, saturation at 99 and level cap.
    run_round(105, 1'b0);

    // Asynchronous reset mid-round with score 07.
    gif.start_btn = 1'b1;
    step();
    gif.start_btn = 1'b0;
    for (int i = 0; i < 12; i++) step();
    for (int h = 0; h < 7; h++) begin
      gif.score_trigger = 1'b1;
      step();
      gif.score_trigger = 1'b0;
    end
    sb_push("score_pre_rst", 32'h07);   sb_pop(32'(gif.score));
    #2 rst = 1'b1;
    #1;
    m_high = 0;
    sb_push("arst_state", 32'd0);       sb_pop(32'(gif.global_state));
    sb_push("arst_score", 32'd0);       sb_pop(32'(gif.score));
    sb_push("arst_board_en", 32'd0);    sb_pop(32'(gif.board_enable));
    sb_push("arst_high", 32'd0);        sb_pop(32'(gif.high_score));
    #2 rst = 1'b0;
    step();

    // Three rounds scoring 07 (last hit on final tick), 05, 09.
    run_round(7, 1'b1);
    run_round(5, 1'b0);
    run_round(9, 1'b0);

    if (sb.size() != 0) check("sb_leftover", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
